// File: rtl/mem_controller_pkg.sv
// Shared types for the memory controller: per-channel state encoding and a helper
// for sizing consumer-index fields.
package mem_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } mem_ctrl_state_t;

  // Width of a consumer index; a single consumer still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_controller_if.sv
// Consumer-side and memory-side valid/ready bundle of the memory controller.
// slave = controller view, master = view of the cores and the memory.
interface mem_controller_if #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
);

  logic [NUM_CONSUMERS-1:0] consumer_read_valid;
  logic [ADDR_WIDTH-1:0]    consumer_read_addr  [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_read_ready;
  logic [DATA_WIDTH-1:0]    consumer_read_data  [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_write_valid;
  logic [ADDR_WIDTH-1:0]    consumer_write_addr [NUM_CONSUMERS];
  logic [DATA_WIDTH-1:0]    consumer_write_data [NUM_CONSUMERS];
  logic [NUM_CONSUMERS-1:0] consumer_write_ready;

  logic [NUM_CHANNELS-1:0]  mem_read_valid;
  logic [ADDR_WIDTH-1:0]    mem_read_addr  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  mem_read_ready;
  logic [DATA_WIDTH-1:0]    mem_read_data  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  mem_write_valid;
  logic [ADDR_WIDTH-1:0]    mem_write_addr [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]    mem_write_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  mem_write_ready;

  modport slave (
    input  consumer_read_valid, consumer_read_addr,
    input  consumer_write_valid, consumer_write_addr, consumer_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_addr,
    output mem_write_valid, mem_write_addr, mem_write_data
  );

  modport master (
    output consumer_read_valid, consumer_read_addr,
    output consumer_write_valid, consumer_write_addr, consumer_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_addr,
    input  mem_write_valid, mem_write_addr, mem_write_data
  );

endinterface

// File: rtl/mem_controller_channel.sv
// One memory channel: latches a granted request, holds mem_*_valid until memory answers,
// then waits for the consumer to drop valid. Grant to mem valid and mem ready to done are 1 cycle.
module mem_controller_channel
  import mem_controller_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int IDX_W        = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_grant,
  input  logic                  i_grant_write,
  input  logic [IDX_W-1:0]      i_grant_idx,
  input  logic [ADDR_WIDTH-1:0] i_grant_addr,
  input  logic [DATA_WIDTH-1:0] i_grant_data,
  input  logic                  i_mem_read_ready,
  input  logic                  i_mem_write_ready,
  input  logic                  i_cons_valid,
  output logic                  o_idle,
  output logic                  o_read_done,
  output logic                  o_write_done,
  output logic                  o_release,
  output logic                  o_is_write,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_mem_read_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_read_addr,
  output logic                  o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_write_addr,
  output logic [DATA_WIDTH-1:0] o_mem_write_data
);

  mem_ctrl_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_is_write;
  logic                  r_rd_vld, r_wr_vld;
  logic [ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  w_grant_write;

  // A read-only build can never enter the write path, so the write registers stay at reset value.
  assign w_grant_write = i_grant_write && (WRITE_ENABLE != 0);

  always_comb begin
    w_state_nxt  = r_state;
    o_read_done  = 1'b0;
    o_write_done = 1'b0;
    o_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_grant) w_state_nxt = w_grant_write ? WRITE_WAITING : READ_WAITING;
      end
      READ_WAITING: begin
        if (i_mem_read_ready) begin
          w_state_nxt = READ_RELAYING;
          o_read_done = 1'b1;
        end
      end
      WRITE_WAITING: begin
        if (i_mem_write_ready) begin
          w_state_nxt  = WRITE_RELAYING;
          o_write_done = 1'b1;
        end
      end
      READ_RELAYING, WRITE_RELAYING: begin
        if (!i_cons_valid) begin
          w_state_nxt = IDLE;
          o_release   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_wr_vld   <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_vld <= (w_state_nxt == READ_WAITING);
      r_wr_vld <= (w_state_nxt == WRITE_WAITING);
      if ((r_state == IDLE) && i_grant) begin
        r_idx      <= i_grant_idx;
        r_is_write <= w_grant_write;
        if (w_grant_write) begin
          r_wr_addr <= i_grant_addr;
          r_wr_data <= i_grant_data;
        end else begin
          r_rd_addr <= i_grant_addr;
        end
      end
    end
  end

  assign o_idle            = (r_state == IDLE);
  assign o_idx             = r_idx;
  assign o_is_write        = r_is_write;
  assign o_mem_read_valid  = r_rd_vld;
  assign o_mem_read_addr   = r_rd_addr;
  assign o_mem_write_valid = r_wr_vld;
  assign o_mem_write_addr  = r_wr_addr;
  assign o_mem_write_data  = r_wr_data;

endmodule

// File: rtl/mem_controller.sv
// Round-robin arbiter of consumer read/write requests onto NUM_CHANNELS memory channels,
// with response demux back to consumers. Requests wait (never dropped) while all channels are busy.
module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1,
  parameter int WRITE_ENABLE  = 1
) (
  input logic              clk,
  input logic              rst,
  mem_controller_if.slave  bus
);

  localparam int CW = idx_width(NUM_CONSUMERS);

  logic [NUM_CONSUMERS-1:0] r_serving, w_serving_nxt, w_pending;
  logic [CW-1:0]            r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_CONSUMERS-1:0] r_rd_rdy, r_wr_rdy;
  logic [DATA_WIDTH-1:0]    r_rd_dat [NUM_CONSUMERS];

  logic [NUM_CHANNELS-1:0]  w_ch_idle, w_grant, w_grant_write;
  logic [NUM_CHANNELS-1:0]  w_rd_done, w_wr_done, w_release, w_ch_is_write, w_ch_cons_valid;
  logic [CW-1:0]            w_grant_idx  [NUM_CHANNELS];
  logic [CW-1:0]            w_ch_idx     [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0]    w_grant_addr [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]    w_grant_data [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  w_mem_rd_vld, w_mem_wr_vld;
  logic [ADDR_WIDTH-1:0]    w_mem_rd_addr [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0]    w_mem_wr_addr [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]    w_mem_wr_data [NUM_CHANNELS];

  assign w_pending = bus.consumer_read_valid |
                     ((WRITE_ENABLE != 0) ? bus.consumer_write_valid : {NUM_CONSUMERS{1'b0}});

  // Channels grant in index order within one cycle; each sees the mask/pointer left by the previous one.
  always_comb begin
    logic [NUM_CONSUMERS-1:0] v_mask;
    logic [CW-1:0]            v_ptr, v_cidx, v_gidx;
    logic                     v_found;
    v_mask  = r_serving;
    v_ptr   = r_rr_ptr;
    v_cidx  = '0;
    v_gidx  = '0;
    v_found = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      w_grant[ch]       = 1'b0;
      w_grant_write[ch] = 1'b0;
      w_grant_idx[ch]   = '0;
      w_grant_addr[ch]  = '0;
      w_grant_data[ch]  = '0;
      if (w_ch_idle[ch]) begin
        v_found = 1'b0;
        v_gidx  = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
          v_cidx = CW'((int'(v_ptr) + i) % NUM_CONSUMERS);
          if (!v_found && w_pending[v_cidx] && !v_mask[v_cidx]) begin
            v_found = 1'b1;
            v_gidx  = v_cidx;
          end
        end
        if (v_found) begin
          w_grant[ch]       = 1'b1;
          w_grant_idx[ch]   = v_gidx;
          w_grant_write[ch] = !bus.consumer_read_valid[v_gidx];
          w_grant_addr[ch]  = bus.consumer_read_valid[v_gidx] ? bus.consumer_read_addr[v_gidx]
                                                              : bus.consumer_write_addr[v_gidx];
          w_grant_data[ch]  = bus.consumer_write_data[v_gidx];
          v_mask[v_gidx]    = 1'b1;
          v_ptr             = CW'((int'(v_gidx) + 1) % NUM_CONSUMERS);
        end
      end
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (w_release[ch]) v_mask[w_ch_idx[ch]] = 1'b0;
    end
    w_serving_nxt = v_mask;
    w_rr_ptr_nxt  = v_ptr;
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign w_ch_cons_valid[g] = w_ch_is_write[g] ? bus.consumer_write_valid[w_ch_idx[g]]
                                                 : bus.consumer_read_valid[w_ch_idx[g]];

    mem_controller_channel #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .IDX_W       (CW),
      .WRITE_ENABLE(WRITE_ENABLE)
    ) u_ch (
      .clk              (clk),
      .rst              (rst),
      .i_grant          (w_grant[g]),
      .i_grant_write    (w_grant_write[g]),
      .i_grant_idx      (w_grant_idx[g]),
      .i_grant_addr     (w_grant_addr[g]),
      .i_grant_data     (w_grant_data[g]),
      .i_mem_read_ready (bus.mem_read_ready[g]),
      .i_mem_write_ready(bus.mem_write_ready[g]),
      .i_cons_valid     (w_ch_cons_valid[g]),
      .o_idle           (w_ch_idle[g]),
      .o_read_done      (w_rd_done[g]),
      .o_write_done     (w_wr_done[g]),
      .o_release        (w_release[g]),
      .o_is_write       (w_ch_is_write[g]),
      .o_idx            (w_ch_idx[g]),
      .o_mem_read_valid (w_mem_rd_vld[g]),
      .o_mem_read_addr  (w_mem_rd_addr[g]),
      .o_mem_write_valid(w_mem_wr_vld[g]),
      .o_mem_write_addr (w_mem_wr_addr[g]),
      .o_mem_write_data (w_mem_wr_data[g])
    );
  end

  // A consumer is owned by at most one channel, so per-channel updates never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_serving <= '0;
      r_rr_ptr  <= '0;
      r_rd_rdy  <= '0;
      r_wr_rdy  <= '0;
      for (int c = 0; c < NUM_CONSUMERS; c++) r_rd_dat[c] <= '0;
    end else begin
      r_serving <= w_serving_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (w_rd_done[ch]) begin
          r_rd_rdy[w_ch_idx[ch]] <= 1'b1;
          r_rd_dat[w_ch_idx[ch]] <= bus.mem_read_data[ch];
        end
        if (w_wr_done[ch]) r_wr_rdy[w_ch_idx[ch]] <= 1'b1;
        if (w_release[ch]) begin
          if (w_ch_is_write[ch]) r_wr_rdy[w_ch_idx[ch]] <= 1'b0;
          else                   r_rd_rdy[w_ch_idx[ch]] <= 1'b0;
        end
      end
    end
  end

  assign bus.consumer_read_ready  = r_rd_rdy;
  assign bus.consumer_read_data   = r_rd_dat;
  assign bus.consumer_write_ready = r_wr_rdy;
  assign bus.mem_read_valid       = w_mem_rd_vld;
  assign bus.mem_read_addr        = w_mem_rd_addr;
  assign bus.mem_write_valid      = w_mem_wr_vld;
  assign bus.mem_write_addr       = w_mem_wr_addr;
  assign bus.mem_write_data       = w_mem_wr_data;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: one-channel, two-channel and read-only instances
// share a clock and reset; each scenario task checks its own hand-computed values.
module tb_mem_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_controller_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) if1 ();
  mem_controller_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) if2 ();
  mem_controller_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) if3 ();

  mem_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1),
                   .WRITE_ENABLE(1)) dut (.clk(clk), .rst(rst), .bus(if1));
  mem_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2),
                   .WRITE_ENABLE(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  mem_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1),
                   .WRITE_ENABLE(0)) dut_ro (.clk(clk), .rst(rst), .bus(if3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    if1.consumer_read_valid = '0; if1.consumer_write_valid = '0;
    if2.consumer_read_valid = '0; if2.consumer_write_valid = '0;
    if3.consumer_read_valid = '0; if3.consumer_write_valid = '0;
    for (int c = 0; c < 4; c++) begin
      if1.consumer_read_addr[c] = '0; if1.consumer_write_addr[c] = '0; if1.consumer_write_data[c] = '0;
      if2.consumer_read_addr[c] = '0; if2.consumer_write_addr[c] = '0; if2.consumer_write_data[c] = '0;
      if3.consumer_read_addr[c] = '0; if3.consumer_write_addr[c] = '0; if3.consumer_write_data[c] = '0;
    end
    if1.mem_read_ready = '0; if1.mem_write_ready = '0; if1.mem_read_data[0] = '0;
    if3.mem_read_ready = '0; if3.mem_write_ready = '0; if3.mem_read_data[0] = '0;
    if2.mem_read_ready = '0; if2.mem_write_ready = '0;
    if2.mem_read_data[0] = '0; if2.mem_read_data[1] = '0;
  endtask

  // Memory responder for the one-channel instance: consumer c reads address 0x40+c and
  // gets 0xC0+c back. Reports who was granted and what the consumer saw.
  task automatic serve_rd1(output int idx, output logic [7:0] dat, output bit ok);
    logic [7:0] a;
    ok  = 1'b0;
    idx = -1;
    dat = '0;
    for (int k = 0; k < 10 && !if1.mem_read_valid[0]; k++) tick();
    if (!if1.mem_read_valid[0]) return;
    a = if1.mem_read_addr[0];
    if (a < 8'h40 || a > 8'h43) return;
    idx = int'(a) - 'h40;
    if1.mem_read_ready[0] = 1'b1;
    if1.mem_read_data[0]  = 8'hC0 + a[7:0] - 8'h40;
    tick();
    if1.mem_read_ready[0] = 1'b0;
    if (!if1.consumer_read_ready[idx]) return;
    dat = if1.consumer_read_data[idx];
    if1.consumer_read_valid[idx] = 1'b0;
    tick();
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if ({if1.mem_read_valid, if1.mem_write_valid, if1.consumer_read_ready, if1.consumer_write_ready} !== 10'h0) begin
      n_fail++; $display("FAIL reset_valids_dut1: got %h want 0",
        {if1.mem_read_valid, if1.mem_write_valid, if1.consumer_read_ready, if1.consumer_write_ready});
    end
    n_tests++;
    if ({if1.mem_read_addr[0], if1.mem_write_addr[0], if1.mem_write_data[0], if1.consumer_read_data[2]} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data_dut1: got %h want 0",
        {if1.mem_read_addr[0], if1.mem_write_addr[0], if1.mem_write_data[0], if1.consumer_read_data[2]});
    end
    n_tests++;
    if ({if2.mem_read_valid, if2.mem_write_valid, if2.consumer_read_ready, if3.mem_read_valid, if3.mem_write_valid} !== 10'h0) begin
      n_fail++; $display("FAIL reset_valids_dut2_ro: got %h want 0",
        {if2.mem_read_valid, if2.mem_write_valid, if2.consumer_read_ready, if3.mem_read_valid, if3.mem_write_valid});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    tick(); tick(); tick();
    n_tests++;
    if ({if1.mem_read_valid, if1.mem_write_valid} !== 2'b00) begin
      n_fail++; $display("FAIL idle_no_request: got %b want 00", {if1.mem_read_valid, if1.mem_write_valid});
    end
    if1.mem_read_ready[0]  = 1'b1;
    if1.mem_write_ready[0] = 1'b1;
    if1.mem_read_data[0]   = 8'hEE;
    tick();
    if1.mem_read_ready[0]  = 1'b0;
    if1.mem_write_ready[0] = 1'b0;
    tick();
    n_tests++;
    if ({if1.consumer_read_ready, if1.consumer_write_ready, if1.consumer_read_data[0]} !== 16'h0) begin
      n_fail++; $display("FAIL idle_stray_mem_ready: got %h want 0",
        {if1.consumer_read_ready, if1.consumer_write_ready, if1.consumer_read_data[0]});
    end
  endtask

  task automatic test_round_robin();
    int         idx;
    logic [7:0] dat;
    bit         ok;
    int         order2 [4] = '{2, 3, 0, 1};
    for (int c = 0; c < 4; c++) if1.consumer_read_addr[c] = 8'h40 + 8'(c);
    if1.consumer_read_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serve_rd1(idx, dat, ok);
      n_tests++;
      if (!ok || idx != k || dat !== 8'hC0 + 8'(k)) begin
        n_fail++; $display("FAIL rr_from0_slot%0d: got ok=%0d consumer=%0d data=%h want consumer=%0d data=%h",
          k, ok, idx, dat, k, 8'hC0 + 8'(k));
      end
    end
    // A lone grant to consumer 1 leaves the pointer at 2.
    if1.consumer_read_valid[1] = 1'b1;
    serve_rd1(idx, dat, ok);
    n_tests++;
    if (!ok || idx != 1) begin
      n_fail++; $display("FAIL rr_single_c1: got ok=%0d consumer=%0d want consumer=1", ok, idx);
    end
    if1.consumer_read_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serve_rd1(idx, dat, ok);
      n_tests++;
      if (!ok || idx != order2[k] || dat !== 8'hC0 + 8'(order2[k])) begin
        n_fail++; $display("FAIL rr_from2_slot%0d: got ok=%0d consumer=%0d data=%h want consumer=%0d",
          k, ok, idx, dat, order2[k]);
      end
    end
    n_tests++;
    if ({if1.consumer_read_ready, if1.mem_read_valid} !== 5'b0) begin
      n_fail++; $display("FAIL rr_drained: got %b want 0", {if1.consumer_read_ready, if1.mem_read_valid});
    end
  endtask

  task automatic test_single_read();
    if1.consumer_read_addr[2]  = 8'h10;
    if1.consumer_read_valid[2] = 1'b1;
    tick();
    n_tests++;
    if (if1.mem_read_valid[0] !== 1'b1 || if1.mem_read_addr[0] !== 8'h10) begin
      n_fail++; $display("FAIL read_request: got valid=%b addr=%h want valid=1 addr=10",
        if1.mem_read_valid[0], if1.mem_read_addr[0]);
    end
    tick(); tick();
    n_tests++;
    if (if1.consumer_read_ready !== 4'b0000 || if1.mem_read_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL read_waiting: got ready=%b memvalid=%b want 0000/1",
        if1.consumer_read_ready, if1.mem_read_valid[0]);
    end
    if1.mem_read_ready[0] = 1'b1;
    if1.mem_read_data[0]  = 8'hAB;
    tick();
    if1.mem_read_ready[0] = 1'b0;
    if1.mem_read_data[0]  = 8'h00;
    n_tests++;
    if (if1.consumer_read_ready !== 4'b0100 || if1.consumer_read_data[2] !== 8'hAB || if1.mem_read_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL read_response: got ready=%b data=%h memvalid=%b want 0100/ab/0",
        if1.consumer_read_ready, if1.consumer_read_data[2], if1.mem_read_valid[0]);
    end
    tick(); tick();
    n_tests++;
    if (if1.consumer_read_ready !== 4'b0100 || if1.consumer_read_data[2] !== 8'hAB) begin
      n_fail++; $display("FAIL read_hold: got ready=%b data=%h want 0100/ab",
        if1.consumer_read_ready, if1.consumer_read_data[2]);
    end
    if1.consumer_read_valid[2] = 1'b0;
    tick();
    n_tests++;
    if (if1.consumer_read_ready !== 4'b0000) begin
      n_fail++; $display("FAIL read_release: got ready=%b want 0000", if1.consumer_read_ready);
    end
  endtask

  task automatic test_write();
    if1.consumer_write_addr[1]  = 8'h20;
    if1.consumer_write_data[1]  = 8'h5A;
    if1.consumer_write_valid[1] = 1'b1;
    tick();
    n_tests++;
    if (if1.mem_write_valid[0] !== 1'b1 || if1.mem_write_addr[0] !== 8'h20 ||
        if1.mem_write_data[0] !== 8'h5A || if1.consumer_write_ready !== 4'b0000) begin
      n_fail++; $display("FAIL write_request: got valid=%b addr=%h data=%h rdy=%b want 1/20/5a/0000",
        if1.mem_write_valid[0], if1.mem_write_addr[0], if1.mem_write_data[0], if1.consumer_write_ready);
    end
    if1.mem_write_ready[0] = 1'b1;
    tick();
    if1.mem_write_ready[0] = 1'b0;
    n_tests++;
    if (if1.consumer_write_ready !== 4'b0010 || if1.mem_write_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL write_done: got rdy=%b memvalid=%b want 0010/0",
        if1.consumer_write_ready, if1.mem_write_valid[0]);
    end
    if1.consumer_write_valid[1] = 1'b0;
    tick();
    n_tests++;
    if (if1.consumer_write_ready !== 4'b0000) begin
      n_fail++; $display("FAIL write_release: got rdy=%b want 0000", if1.consumer_write_ready);
    end
  endtask

  task automatic test_read_write_same();
    if1.consumer_read_addr[3]   = 8'h33;
    if1.consumer_write_addr[3]  = 8'h34;
    if1.consumer_write_data[3]  = 8'h77;
    if1.consumer_read_valid[3]  = 1'b1;
    if1.consumer_write_valid[3] = 1'b1;
    tick();
    n_tests++;
    if (if1.mem_read_valid[0] !== 1'b1 || if1.mem_write_valid[0] !== 1'b0 || if1.mem_read_addr[0] !== 8'h33) begin
      n_fail++; $display("FAIL rw_read_first: got rv=%b wv=%b addr=%h want 1/0/33",
        if1.mem_read_valid[0], if1.mem_write_valid[0], if1.mem_read_addr[0]);
    end
    if1.mem_read_ready[0] = 1'b1;
    if1.mem_read_data[0]  = 8'h99;
    tick();
    if1.mem_read_ready[0] = 1'b0;
    n_tests++;
    if (if1.consumer_read_ready !== 4'b1000 || if1.consumer_read_data[3] !== 8'h99 || if1.consumer_write_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rw_read_done: got rrdy=%b data=%h wrdy=%b want 1000/99/0000",
        if1.consumer_read_ready, if1.consumer_read_data[3], if1.consumer_write_ready);
    end
    if1.consumer_read_valid[3] = 1'b0;
    tick();
    n_tests++;
    if (if1.consumer_read_ready !== 4'b0000 || if1.mem_write_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL rw_gap: got rrdy=%b wv=%b want 0000/0", if1.consumer_read_ready, if1.mem_write_valid[0]);
    end
    tick();
    n_tests++;
    if (if1.mem_write_valid[0] !== 1'b1 || if1.mem_write_addr[0] !== 8'h34 || if1.mem_write_data[0] !== 8'h77) begin
      n_fail++; $display("FAIL rw_write_grant: got wv=%b addr=%h data=%h want 1/34/77",
        if1.mem_write_valid[0], if1.mem_write_addr[0], if1.mem_write_data[0]);
    end
    if1.mem_write_ready[0] = 1'b1;
    tick();
    if1.mem_write_ready[0] = 1'b0;
    n_tests++;
    if (if1.consumer_write_ready !== 4'b1000) begin
      n_fail++; $display("FAIL rw_write_done: got wrdy=%b want 1000", if1.consumer_write_ready);
    end
    if1.consumer_write_valid[3] = 1'b0;
    tick();
  endtask

  task automatic test_two_channels();
    for (int c = 0; c < 3; c++) if2.consumer_read_addr[c] = 8'h40 + 8'(c);
    if2.consumer_read_valid = 4'b0111;
    tick();
    n_tests++;
    if (if2.mem_read_valid !== 2'b11 || if2.mem_read_addr[0] !== 8'h40 || if2.mem_read_addr[1] !== 8'h41) begin
      n_fail++; $display("FAIL ch2_parallel_grant: got v=%b a0=%h a1=%h want 11/40/41",
        if2.mem_read_valid, if2.mem_read_addr[0], if2.mem_read_addr[1]);
    end
    if2.mem_read_ready   = 2'b10;
    if2.mem_read_data[1] = 8'hB1;
    tick();
    if2.mem_read_ready   = 2'b00;
    n_tests++;
    if (if2.consumer_read_ready !== 4'b0010 || if2.consumer_read_data[1] !== 8'hB1 || if2.mem_read_valid !== 2'b01) begin
      n_fail++; $display("FAIL ch2_c1_done: got rdy=%b data=%h v=%b want 0010/b1/01",
        if2.consumer_read_ready, if2.consumer_read_data[1], if2.mem_read_valid);
    end
    if2.consumer_read_valid[1] = 1'b0;
    tick();
    n_tests++;
    if (if2.consumer_read_ready !== 4'b0000 || if2.mem_read_valid !== 2'b01) begin
      n_fail++; $display("FAIL ch2_c2_waits: got rdy=%b v=%b want 0000/01", if2.consumer_read_ready, if2.mem_read_valid);
    end
    tick();
    n_tests++;
    if (if2.mem_read_valid !== 2'b11 || if2.mem_read_addr[1] !== 8'h42 || if2.mem_read_addr[0] !== 8'h40) begin
      n_fail++; $display("FAIL ch2_c2_on_freed: got v=%b a0=%h a1=%h want 11/40/42",
        if2.mem_read_valid, if2.mem_read_addr[0], if2.mem_read_addr[1]);
    end
    if2.mem_read_ready   = 2'b11;
    if2.mem_read_data[0] = 8'hB0;
    if2.mem_read_data[1] = 8'hB2;
    tick();
    if2.mem_read_ready   = 2'b00;
    n_tests++;
    if (if2.consumer_read_ready !== 4'b0101 || if2.consumer_read_data[0] !== 8'hB0 || if2.consumer_read_data[2] !== 8'hB2) begin
      n_fail++; $display("FAIL ch2_both_done: got rdy=%b d0=%h d2=%h want 0101/b0/b2",
        if2.consumer_read_ready, if2.consumer_read_data[0], if2.consumer_read_data[2]);
    end
    if2.consumer_read_valid = 4'b0000;
    tick(); tick();
    n_tests++;
    if (if2.consumer_read_ready !== 4'b0000 || if2.mem_read_valid !== 2'b00) begin
      n_fail++; $display("FAIL ch2_drained: got rdy=%b v=%b want 0000/00", if2.consumer_read_ready, if2.mem_read_valid);
    end
  endtask

  task automatic test_reset_mid();
    if1.consumer_read_addr[0]  = 8'h50;
    if1.consumer_read_valid[0] = 1'b1;
    tick();
    n_tests++;
    if (if1.mem_read_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got v=%b want 1", if1.mem_read_valid[0]);
    end
    rst = 1'b1;
    if1.consumer_read_valid[0] = 1'b0;
    tick();
    n_tests++;
    if (if1.mem_read_valid[0] !== 1'b0 || if1.mem_read_addr[0] !== 8'h00 || if1.consumer_read_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_cleared: got v=%b addr=%h rdy=%b want 0/00/0000",
        if1.mem_read_valid[0], if1.mem_read_addr[0], if1.consumer_read_ready);
    end
    rst = 1'b0;
    if1.consumer_read_addr[0]  = 8'h55;
    if1.consumer_read_valid[0] = 1'b1;
    tick();
    n_tests++;
    if (if1.mem_read_valid[0] !== 1'b1 || if1.mem_read_addr[0] !== 8'h55) begin
      n_fail++; $display("FAIL rstmid_fresh_req: got v=%b addr=%h want 1/55", if1.mem_read_valid[0], if1.mem_read_addr[0]);
    end
    if1.mem_read_ready[0] = 1'b1;
    if1.mem_read_data[0]  = 8'h66;
    tick();
    if1.mem_read_ready[0] = 1'b0;
    n_tests++;
    if (if1.consumer_read_ready !== 4'b0001 || if1.consumer_read_data[0] !== 8'h66) begin
      n_fail++; $display("FAIL rstmid_fresh_done: got rdy=%b data=%h want 0001/66",
        if1.consumer_read_ready, if1.consumer_read_data[0]);
    end
    if1.consumer_read_valid[0] = 1'b0;
    tick();
  endtask

  task automatic test_read_only();
    if3.consumer_write_addr[0]  = 8'h20;
    if3.consumer_write_data[0]  = 8'h5A;
    if3.consumer_write_valid[0] = 1'b1;
    if3.consumer_read_addr[1]   = 8'h21;
    if3.consumer_read_valid[1]  = 1'b1;
    tick();
    n_tests++;
    if (if3.mem_read_valid[0] !== 1'b1 || if3.mem_read_addr[0] !== 8'h21 || if3.mem_write_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL ro_read_grant: got rv=%b addr=%h wv=%b want 1/21/0",
        if3.mem_read_valid[0], if3.mem_read_addr[0], if3.mem_write_valid[0]);
    end
    if3.mem_write_ready[0] = 1'b1;
    tick();
    if3.mem_write_ready[0] = 1'b0;
    n_tests++;
    if ({if3.mem_write_valid[0], if3.mem_write_addr[0], if3.mem_write_data[0], if3.consumer_write_ready} !== 21'h0) begin
      n_fail++; $display("FAIL ro_write_outputs: got %h want 0",
        {if3.mem_write_valid[0], if3.mem_write_addr[0], if3.mem_write_data[0], if3.consumer_write_ready});
    end
    if3.mem_read_ready[0] = 1'b1;
    if3.mem_read_data[0]  = 8'h3C;
    tick();
    if3.mem_read_ready[0] = 1'b0;
    n_tests++;
    if (if3.consumer_read_ready !== 4'b0010 || if3.consumer_read_data[1] !== 8'h3C) begin
      n_fail++; $display("FAIL ro_read_done: got rdy=%b data=%h want 0010/3c",
        if3.consumer_read_ready, if3.consumer_read_data[1]);
    end
    if3.consumer_read_valid[1] = 1'b0;
    tick(); tick(); tick();
    n_tests++;
    if ({if3.mem_read_valid[0], if3.mem_write_valid[0], if3.consumer_write_ready, if3.consumer_read_ready} !== 10'h0) begin
      n_fail++; $display("FAIL ro_write_ignored: got %b want 0",
        {if3.mem_read_valid[0], if3.mem_write_valid[0], if3.consumer_write_ready, if3.consumer_read_ready});
    end
    if3.consumer_write_valid[0] = 1'b0;
    tick();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_idle();
    test_round_robin();
    test_single_read();
    test_write();
    test_read_write_same();
    test_two_channels();
    test_read_only();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Responder end of the core's valid/ready memory interfaces.
- Accepts per-consumer read/write requests from core LSUs or fetchers.
- Arbitrates them onto NUM_CHANNELS memory channels and relays each response back to the requesting consumer.
- One instance sits between all cores and data memory; a read-only instance (WRITE_ENABLE=0) serves program memory.

Parameters:
- ADDR_WIDTH, 8, memory address width
- DATA_WIDTH, 8, memory data width
- NUM_CONSUMERS, 4, number of requesting ports (LSUs or fetchers)
- NUM_CHANNELS, 1, concurrent memory transactions supported
- WRITE_ENABLE, 1, 0 = read-only; write logic absent, write outputs tied 0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  read request per consumer
- consumer_read_addr  in  ADDR_WIDTH x NUM_CONSUMERS (unpacked)  read address
- consumer_read_ready  out  NUM_CONSUMERS  read data valid and held
- consumer_read_data  out  DATA_WIDTH x NUM_CONSUMERS (unpacked)  read data
- consumer_write_valid  in  NUM_CONSUMERS  write request
- consumer_write_addr  in  ADDR_WIDTH x NUM_CONSUMERS  write address
- consumer_write_data  in  DATA_WIDTH x NUM_CONSUMERS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write complete and held
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_read_addr  out  ADDR_WIDTH x NUM_CHANNELS  channel read address
- mem_read_ready  in  NUM_CHANNELS  memory read done
- mem_read_data  in  DATA_WIDTH x NUM_CHANNELS  memory read data
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_write_addr  out  ADDR_WIDTH x NUM_CHANNELS  channel write address
- mem_write_data  out  DATA_WIDTH x NUM_CHANNELS  channel write data
- mem_write_ready  in  NUM_CHANNELS  memory write done

Behaviour:
- All outputs are registered.
- Reset (rst=1 at posedge):
  - all outputs 0, all channels IDLE, serving mask 0, rr_ptr 0.
  - Reset mid-transaction abandons in-flight requests; mem_*_valid drops next cycle.
- Consumer protocol:
  - Consumer raises valid with address/data and holds it until it sees ready.
  - Controller holds ready (and read data) until the consumer drops valid.
  - Ready falls the cycle after valid is sampled low.
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
  - IDLE: grants the next pending consumer that is not already being served. Read takes priority over write for that consumer. The grant latches the consumer index, addr and data, asserts mem_read_valid or mem_write_valid next cycle, and goes to *_WAITING.
  - READ_WAITING: on mem_read_ready=1, drop mem_read_valid, drive consumer_read_data from mem_read_data, assert consumer_read_ready, go to READ_RELAYING.
  - WRITE_WAITING: same handshake with mem_write_ready, then WRITE_RELAYING.
  - *_RELAYING: when the consumer's valid is low, deassert ready, clear the serving bit, go to IDLE.
- Arbitration:
  - Round-robin search starts at rr_ptr; after each grant rr_ptr = grantee+1 mod NUM_CONSUMERS.
  - When several channels are IDLE in the same cycle, they grant sequentially: channel 0 first, and later channels see the updated mask and pointer. A consumer is never granted to two channels.
- Latency:
  - valid sampled at edge t → mem_*_valid high after t+1.
  - mem_*_ready sampled at edge u → consumer ready high after u+1.
  - Minimum read round trip is 2 cycles plus memory latency.
- Boundaries:
  - No pending requests: channels stay IDLE.
  - All channels busy: requests wait, with no loss.
  - A consumer with both read and write valid gets its read served first; its write is served on a later grant.
  - mem_*_ready asserted outside *_WAITING is ignored.
  - WRITE_ENABLE=0: write requests are never granted; write outputs are constant 0.

Decomposition:
- gpu_pkg gains mem_ctrl_state_t (5-state enum).
- The per-channel FSM is a natural sub-module, mem_channel. The top keeps the round-robin arbiter, the serving mask, and the demultiplexing of responses to consumers.

Test Plan:
- Single read: consumer 2 reads addr 0x10, memory returns 0xAB after 3 cycles.
  - Expect mem_read_addr=0x10.
  - Expect consumer_read_data[2]=0xAB with ready held until valid drops, then ready low next cycle.
- Round-robin, 1 channel: all 4 consumers read simultaneously → grant order 0,1,2,3. With rr_ptr=2 at start, order is 2,3,0,1.
- Two channels: 3 concurrent reads → consumers 0 and 1 are granted in the same cycle on channels 0 and 1. Consumer 2 is granted on the first freed channel, and no consumer is ever double-granted.
- Write: consumer 1 writes 0x5A to 0x20 → mem_write_addr=0x20, mem_write_data=0x5A. consumer_write_ready[1] asserts the cycle after mem_write_ready.
- Read+write same consumer: both valid → the read completes first, then the write is granted once the read valid drops.
- Reset mid-READ_WAITING: assert rst → next cycle all outputs are 0. After rst drops, a fresh read completes correctly; WRITE_ENABLE=0 build ignores writes.
